// File: rtl/serial_deserializer_pkg.sv
// serial_deserializer_pkg
// Shared definitions for the serial deserializer: the receive FSM state
// type and the default word width.
package serial_deserializer_pkg;

  // Default word width in bits (legal range 2..32).
  localparam int DEFAULT_N = 8;

  // Receive FSM: waiting for a frame start, or shifting in bits.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/serial_deserializer_rx_bit_counter.sv
// serial_deserializer_rx_bit_counter
// Counts captured bits of the word being received.
// Ports:
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset, count forced to 0
//   clr  - synchronous clear to 0 (wins over inc)
//   inc  - advance by one captured bit; wraps to 0 after n-1
//   tc   - terminal count: the next captured bit completes the word
module serial_deserializer_rx_bit_counter
  import serial_deserializer_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  logic [CW-1:0] cnt_r;

  // Bit counter: clear has priority, never counts past n-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == LAST);

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer
// Collects LSB-first serial bits into n-bit words and hands them to a
// consumer through a one-entry valid/ready output buffer.
// Ports:
//   clk     - clock, rising edge
//   rstn    - asynchronous active-low reset
//   si      - serial data bit, captured when en=1 while receiving
//   en      - bit strobe
//   start   - begin a new word, discarding any partial word
//   dready  - consumer accepts dout when dvalid=1
//   clr_ovr - clear the sticky overrun flag
//   dout    - last completed word (registered)
//   dvalid  - dout holds an unconsumed word
//   busy    - receiving a word
//   overrun - sticky: a completed word was dropped because dout was full
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         si,
  input  logic         en,
  input  logic         start,
  input  logic         dready,
  input  logic         clr_ovr,
  output logic [n-1:0] dout,
  output logic         dvalid,
  output logic         busy,
  output logic         overrun
);

  state_e       state_r;
  logic [n-1:0] sh_r;
  logic         in_recv_s;
  logic         tc_s;
  logic         complete_s;
  logic         shift_s;
  logic         drop_s;
  logic [n-1:0] word_s;

  assign in_recv_s = (state_r == RECV);
  // A word completes on the n-th captured bit even when start is also high;
  // otherwise start overrides the strobe and throws the partial word away.
  assign complete_s = in_recv_s & en & tc_s;
  assign shift_s    = in_recv_s & en & ~start;
  assign word_s     = {si, sh_r[n-1:1]};
  assign drop_s     = complete_s & dvalid & ~dready;

  serial_deserializer_rx_bit_counter #(.n(n)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (start | complete_s),
    .inc  (in_recv_s & en),
    .tc   (tc_s)
  );

  // Receive FSM with registered busy flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RECV;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RECV: begin
          if (complete_s && !start) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= RECV;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Shift register: right shift, new bit enters at the MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_r <= {n{1'b0}};
    end else if (shift_s) begin
      sh_r <= word_s;
    end else begin
      sh_r <= sh_r;
    end
  end

  // Output buffer: load on completion when empty or being drained,
  // otherwise drop the new word and flag the overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout    <= {n{1'b0}};
      dvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete_s && !drop_s) begin
        dout   <= word_s;
        dvalid <= 1'b1;
      end else if (dvalid && dready && !complete_s) begin
        dout   <= dout;
        dvalid <= 1'b0;
      end else begin
        dout   <= dout;
        dvalid <= dvalid;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer (n=8): a word-level reference
// model pushes expected words into a queue, a monitor pops them on every
// output handshake and also compares the status flags each cycle.
module tb_serial_deserializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         si, en, start, dready, clr_ovr;
  logic [N-1:0] dout;
  logic         dvalid, busy, overrun;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.n(N)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .si      (si),
    .en      (en),
    .start   (start),
    .dready  (dready),
    .clr_ovr (clr_ovr),
    .dout    (dout),
    .dvalid  (dvalid),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (word level) ----------------
  bit           m_recv, m_valid, m_ovr;
  bit           m_bits[$];
  logic [N-1:0] exp_q[$];
  bit           m_done, m_drop;
  logic [N-1:0] m_w;

  task automatic model_step();
    if (!rstn) begin
      m_recv = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
      m_bits.delete(); exp_q.delete();
      return;
    end
    m_done = 1'b0;
    if (m_recv && en && m_bits.size() == N - 1) begin
      m_bits.push_back(si);
      m_w = '0;
      for (int i = 0; i < N; i++) m_w[i] = m_bits[i];
      m_done = 1'b1;
      m_bits.delete();
      m_recv = start;
    end else if (m_recv && start) begin
      m_bits.delete();
    end else if (m_recv && en) begin
      m_bits.push_back(si);
    end else if (!m_recv && start) begin
      m_recv = 1'b1;
      m_bits.delete();
    end
    m_drop = m_done && m_valid && !dready;
    if (m_done && !m_drop) begin
      m_valid = 1'b1;
      exp_q.push_back(m_w);
    end else if (!m_done && m_valid && dready) begin
      m_valid = 1'b0;
    end
    if (m_drop) m_ovr = 1'b1;
    else if (clr_ovr) m_ovr = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("dvalid", dvalid, m_valid);
      check("overrun", overrun, m_ovr);
      check("busy", busy, m_recv);
      if (dvalid && dready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL dout: got unexpected word 0x%0h, expected none at %0t", dout, $time);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic s, input logic e, input logic b, input logic r, input logic c);
    start = s; en = e; si = b; dready = r; clr_ovr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] w, input logic r, input bit gaps,
                      input bit lead_start, input bit start_last);
    if (lead_start) cyc(1'b1, 1'b1, 1'($urandom), r, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (gaps) cyc(1'b0, 1'b0, 1'($urandom), r, 1'b0);
      cyc(start_last && (i == N - 1), 1'b1, w[i], r, 1'b0);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; en = 1'b0; si = 1'b0; dready = 1'b0; clr_ovr = 1'b0;
    #1;
    check("reset_dout", dout, 0);
    check("reset_dvalid", dvalid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    // 0xA5 with dready high, then with en toggling
    send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 0x3C held, 0xC3 dropped -> overrun, then cleared
    send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_dout", dout, 8'h3C);
    check("overrun_set", overrun, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("overrun_clr", overrun, 0);
    check("held_dout_after_clr", dout, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // four bits, restart, then 0xFF
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    check("restart_dout", dout, 8'hFF);
    check("restart_no_ovr", overrun, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame, then bits without start
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check("midreset_dout", dout, 0);
    check("midreset_dvalid", dvalid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_overrun", overrun, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("no_start_dvalid", dvalid, 0);

    // back-to-back 0x01 then 0x80 with start in the completion cycle
    send(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    check("b2b_first", dout, 8'h01);
    check("b2b_busy", busy, 1);
    send(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b_second", dout, 8'h80);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(0, 15) == 0));
    end

    // drain
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
